// File: rtl/perceptron_predictor.sv
// rtl/perceptron_predictor.sv - online perceptron core for the two-button guess-my-next-press game
// Define WEIGHT_NORM_EN to add the sum-of-squares check that halves every weight past NORM_LIMIT.
module perceptron_predictor #(
  parameter int     HIST_LEN     = 20,
  parameter int     W            = 10,
  parameter int     ETA          = 2,
  parameter int     DEBOUNCE_CYC = 500000,
  parameter int     SCORE_W      = 8,
  parameter int     TARGET       = 100,
  parameter longint NORM_LIMIT   = longint'(1) << (2*W-4)
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               k1,
  input  logic               k2,
  output logic               pred,
  output logic               pred_valid,
  output logic               busy,
  output logic [SCORE_W-1:0] score_machine,
  output logic [SCORE_W-1:0] score_human,
  output logic               game_over,
  output logic [7:0]         led
);
  localparam int IDX_W = (HIST_LEN > 1) ? $clog2(HIST_LEN) : 1;
  localparam int ACC_W = W + $clog2(HIST_LEN) + 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic signed [W:0]  W_MAX     = (W+1)'((2 ** (W-1)) - 1);
  localparam logic signed [W:0]  W_MIN     = -W_MAX;
  localparam logic signed [W:0]  ETA_V     = (W+1)'(ETA);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(HIST_LEN - 1);
  localparam logic [SCORE_W-1:0] SCORE_TGT = SCORE_W'(TARGET);
  localparam logic [CNT_W-1:0]   LOCK_LOAD = CNT_W'(DEBOUNCE_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_EVAL, S_UPDATE,
`ifdef WEIGHT_NORM_EN
    S_NORM, S_HALVE,
`endif
    S_SHIFT, S_PREDICT
  } state_t;

  state_t state_q, state_d;
  logic [1:0] sync1_q, sync2_q, sync3_q;  // bit 1 tracks k1, bit 0 tracks k2
  logic [1:0] fall, accept;
  logic [CNT_W-1:0] lock1_q, lock1_d, lock2_q, lock2_d;
  logic ev_q, ev_d, b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [HIST_LEN-1:0] hist_q, hist_d;
  logic signed [W-1:0] w_q [HIST_LEN];
  logic signed [W-1:0] w_d [HIST_LEN];
  logic signed [ACC_W-1:0] acc_q, acc_d, term;
  logic signed [W:0] w_ext, upd_sum;
  logic signed [W-1:0] upd_w;
  logic pred_q, pred_d, last;
  logic [SCORE_W-1:0] sm_q, sm_d, sh_q, sh_d;

`ifdef WEIGHT_NORM_EN
  localparam int SQ_W = 2*W + $clog2(HIST_LEN);
  localparam logic [SQ_W-1:0] SQ_LIMIT = SQ_W'(NORM_LIMIT);
  logic [SQ_W-1:0] sq_q, sq_d;
  logic signed [2*W-1:0] w_wide, w_sq;
`else
  logic unused_norm_limit;
  assign unused_norm_limit = (NORM_LIMIT != 0);
`endif

  assign game_over = (sm_q == SCORE_TGT) || (sh_q == SCORE_TGT);

  always_comb begin
    fall    = sync3_q & ~sync2_q;
    accept  = {fall[1] & (lock1_q == '0), fall[0] & (lock2_q == '0)};
    lock1_d = accept[1] ? LOCK_LOAD : ((lock1_q != '0) ? lock1_q - CNT_W'(1) : lock1_q);
    lock2_d = accept[0] ? LOCK_LOAD : ((lock2_q != '0) ? lock2_q - CNT_W'(1) : lock2_q);
    // Simultaneous edges cancel; edges outside IDLE are dropped but still arm their lockout
    ev_d = ((accept == 2'b10) || (accept == 2'b01)) && (state_q == S_IDLE) && !ev_q && !game_over;
    b_d  = ev_d ? accept[1] : b_q;
  end

  always_comb begin
    last    = (idx_q == IDX_LAST);
    w_ext   = (W+1)'(w_q[idx_q]);
    term    = ACC_W'(w_q[idx_q]);
    if (!hist_q[idx_q]) term = -term;
    upd_sum = (b_q == hist_q[idx_q]) ? w_ext + ETA_V : w_ext - ETA_V;
    if (upd_sum > W_MAX)      upd_w = W_MAX[W-1:0];
    else if (upd_sum < W_MIN) upd_w = W_MIN[W-1:0];
    else                      upd_w = upd_sum[W-1:0];
`ifdef WEIGHT_NORM_EN
    w_wide = (2*W)'(w_q[idx_q]);
    w_sq   = w_wide * w_wide;
    sq_d   = sq_q;
`endif
    state_d = state_q;
    idx_d   = idx_q;
    hist_d  = hist_q;
    acc_d   = acc_q;
    pred_d  = pred_q;
    sm_d    = sm_q;
    sh_d    = sh_q;
    w_d     = w_q;
    case (state_q)
      S_IDLE: if (ev_q) state_d = S_EVAL;
      S_EVAL: begin
        idx_d = '0;
        if (b_q == pred_q) begin
          if (sm_q < SCORE_TGT) sm_d = sm_q + SCORE_W'(1);
          state_d = S_SHIFT;
        end else begin
          if (sh_q < SCORE_TGT) sh_d = sh_q + SCORE_W'(1);
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        w_d[idx_q] = upd_w;
        idx_d = idx_q + IDX_W'(1);
        if (last) begin
          idx_d = '0;
`ifdef WEIGHT_NORM_EN
          sq_d    = '0;
          state_d = S_NORM;
`else
          state_d = S_SHIFT;
`endif
        end
      end
`ifdef WEIGHT_NORM_EN
      S_NORM: begin
        sq_d  = sq_q + SQ_W'($unsigned(w_sq));
        idx_d = idx_q + IDX_W'(1);
        if (last) begin
          idx_d   = '0;
          state_d = (sq_d > SQ_LIMIT) ? S_HALVE : S_SHIFT;
        end
      end
      S_HALVE: begin
        for (int i = 0; i < HIST_LEN; i++) w_d[i] = w_q[i] >>> 1;
        state_d = S_SHIFT;
      end
`endif
      S_SHIFT: begin
        hist_d  = {hist_q[HIST_LEN-2:0], b_q};
        acc_d   = '0;
        idx_d   = '0;
        state_d = S_PREDICT;
      end
      S_PREDICT: begin
        acc_d = acc_q + term;
        idx_d = idx_q + IDX_W'(1);
        if (last) begin
          idx_d   = '0;
          pred_d  = !acc_d[ACC_W-1];
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      sync3_q <= 2'b11;
      lock1_q <= '0;
      lock2_q <= '0;
      ev_q    <= 1'b0;
      b_q     <= 1'b0;
      idx_q   <= '0;
      hist_q  <= '0;
      acc_q   <= '0;
      pred_q  <= 1'b1;
      sm_q    <= '0;
      sh_q    <= '0;
      for (int i = 0; i < HIST_LEN; i++) w_q[i] <= '0;
`ifdef WEIGHT_NORM_EN
      sq_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= {k1, k2};
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      lock1_q <= lock1_d;
      lock2_q <= lock2_d;
      ev_q    <= ev_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      hist_q  <= hist_d;
      acc_q   <= acc_d;
      pred_q  <= pred_d;
      sm_q    <= sm_d;
      sh_q    <= sh_d;
      for (int i = 0; i < HIST_LEN; i++) w_q[i] <= w_d[i];
`ifdef WEIGHT_NORM_EN
      sq_q    <= sq_d;
`endif
    end
  end

  assign pred          = pred_q;
  assign busy          = (state_q != S_IDLE);
  assign pred_valid    = (state_q == S_IDLE);
  assign score_machine = sm_q;
  assign score_human   = sh_q;
  assign led           = {sm_q[3:0], sh_q[3:0]};
endmodule

// File: tb/tb_perceptron_predictor.sv
// tb/tb_perceptron_predictor.sv - randomized presses checked against a behavioural game model
module tb_perceptron_predictor;
  localparam int N    = 4;
  localparam int W    = 10;
  localparam int ETA  = 2;
  localparam int DEB  = 4;
  localparam int TGT  = 3;
  localparam int WLIM = 2 ** (W-1) - 1;

  logic       clk = 1'b0;
  logic       reset, k1, k2;
  logic       pred, pred_valid, busy, game_over;
  logic [7:0] score_machine, score_human, led;

  always #5 clk = ~clk;

  perceptron_predictor #(
    .HIST_LEN(N), .W(W), .ETA(ETA), .DEBOUNCE_CYC(DEB), .SCORE_W(8), .TARGET(TGT)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .k1(k1), .k2(k2),
    .pred(pred), .pred_valid(pred_valid), .busy(busy),
    .score_machine(score_machine), .score_human(score_human),
    .game_over(game_over), .led(led)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int mw [N];
  int mh [N];   // mh[0] is the newest press
  int m_sm, m_sh, m_pred;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int model_sum();
    int s = 0;
    for (int i = 0; i < N; i++) s += (mh[i] != 0 ? 1 : -1) * mw[i];
    return s;
  endfunction

  function automatic int model_over();
    return (m_sm == TGT || m_sh == TGT) ? 1 : 0;
  endfunction

  task automatic check_state(input string tag);
    int hv = 0;
    for (int i = 0; i < N; i++) hv |= mh[i] << i;
    check({tag, ".sm"}, int'(score_machine), m_sm);
    check({tag, ".sh"}, int'(score_human), m_sh);
    check({tag, ".pred"}, int'(pred), m_pred);
    check({tag, ".pred_valid"}, int'(pred_valid), 1);
    check({tag, ".busy"}, int'(busy), 0);
    check({tag, ".led"}, int'(led), ((m_sm & 15) << 4) | (m_sh & 15));
    check({tag, ".game_over"}, int'(game_over), model_over());
    check({tag, ".hist"}, int'(dut.hist_q), hv);
    check({tag, ".acc"}, int'(dut.acc_q), model_sum());
    for (int i = 0; i < N; i++) check({tag, ".w"}, int'(dut.w_q[i]), mw[i]);
  endtask

  task automatic do_reset();
    k1 = 1'b1;
    k2 = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_sm = 0;
    m_sh = 0;
    m_pred = 1;
    for (int i = 0; i < N; i++) begin
      mw[i] = 0;
      mh[i] = 0;
    end
    @(negedge clk);
    check_state("reset");
  endtask

  task automatic press(input int b, input int inject, input int bounce, input string tag);
    int lat, len, seen, exp_ev, exp_len, v;
    exp_ev = !model_over();
    if (b != 0) k1 = 1'b0; else k2 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bounce != 0 && lat == 1) begin if (b != 0) k1 = 1'b1; else k2 = 1'b1; end
      if (bounce != 0 && lat == 2) begin if (b != 0) k1 = 1'b0; else k2 = 1'b0; end
    end while (!busy && lat < 12);
    if (exp_ev != 0) begin
      check({tag, ".latency"}, lat, 4);
      len = 0;
      while (busy && len < 40) begin
        len++;
        if (inject != 0 && len == 1) begin if (b != 0) k2 = 1'b0; else k1 = 1'b0; end
        @(negedge clk);
      end
      if (b == m_pred) begin
        if (m_sm < TGT) m_sm++;
        exp_len = N + 2;
      end else begin
        if (m_sh < TGT) m_sh++;
        for (int i = 0; i < N; i++) begin
          v = mw[i] + ETA * (b != 0 ? 1 : -1) * (mh[i] != 0 ? 1 : -1);
          mw[i] = (v > WLIM) ? WLIM : ((v < -WLIM) ? -WLIM : v);
        end
        exp_len = 2 * N + 2;
      end
      for (int i = N - 1; i > 0; i--) mh[i] = mh[i-1];
      mh[0] = b;
      m_pred = (model_sum() >= 0) ? 1 : 0;
      check({tag, ".busy_len"}, len, exp_len);
    end else begin
      check({tag, ".no_event"}, int'(busy), 0);
    end
    k1 = 1'b1;
    k2 = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy) seen++;
    end
    check({tag, ".single_event"}, seen, 0);
    check_state(tag);
  endtask

  task automatic both_press();
    int seen = 0;
    k1 = 1'b0;
    k2 = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy) seen++;
    end
    check("both.no_event", seen, 0);
    k1 = 1'b1;
    k2 = 1'b1;
    repeat (8) @(negedge clk);
    check_state("both");
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    k1 = 1'b1;
    k2 = 1'b1;

    do_reset();
    press(1, 0, 0, "k1_first");
    check("k1_first.led_const", int'(led), 8'h10);

    do_reset();
    press(0, 0, 0, "k2_first");
    check("k2_first.acc_const", int'(dut.acc_q), -8);
    check("k2_first.pred_const", int'(pred), 0);

    do_reset();
    press(1, 0, 1, "bounce");
    check("bounce.sm_const", int'(score_machine), 1);

    do_reset();
    both_press();
    press(1, 1, 0, "dropped");

    do_reset();
    for (int i = 0; i < 3; i++) press(i % 2, 0, 0, "alternate");
    check("alternate.sh_const", int'(score_human), 3);
    check("alternate.over_const", int'(game_over), 1);
    press(1, 0, 0, "over_extra");

    repeat (6) begin
      do_reset();
      guard = 0;
      while (!model_over() && guard < 10) begin
        press(int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1 : 0, 0, "rand");
        guard++;
      end
      press(int'($urandom_range(0, 1)), 0, 0, "rand_over");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
